// File: rtl/ep_rom_pkg.sv
// Shared constants and enums for the ROM/RAM array arbiter.
package ep_rom_pkg;

   localparam int ROM_AW      = 17;
   localparam int MAXWAIT_DEF = 4;

   typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_e;
   typedef enum logic {ST_IDLE, ST_RDPEND} state_e;

endpackage

// File: rtl/rom_arb_starve.sv
// Port B starvation guard: counts consecutive cycles B loses to A, saturating at MAXWAIT.
module rom_arb_starve
   import ep_rom_pkg::*;
#(
   parameter int MAXWAIT = MAXWAIT_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic b_req,
   input  logic a_win,
   input  logic b_win,
   output logic starve_b
);

   localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

   logic [3:0] wait_b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wait_b <= '0;
      end else if (!b_req || b_win) begin
         wait_b <= '0;
      end else if (a_win && (wait_b != WAIT_MAX)) begin
         wait_b <= wait_b + 4'd1;
      end
   end

   assign starve_b = (wait_b == WAIT_MAX);

endmodule

// File: rtl/rom_arb.sv
// Two-port arbiter/sequencer for the single-port ROM/RAM array; port A has priority.
// Build option ROM_WP_EN adds a wp input that silently drops port A writes.
//
// state     | meaning
// ST_IDLE   | no read outstanding
// ST_RDPEND | a read returns this cycle
module rom_arb
   import ep_rom_pkg::*;
#(
   parameter int AW      = ROM_AW,
   parameter int MAXWAIT = MAXWAIT_DEF
) (
   input  logic          clock,
   input  logic          reset,
`ifdef ROM_WP_EN
   input  logic          wp,
`endif
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   input  logic          a_we,
   input  logic [7:0]    a_d,
   output logic          a_ack,
   output logic [7:0]    a_q,
   output logic          a_qv,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   input  logic          b_we,
   input  logic [7:0]    b_d,
   output logic          b_ack,
   output logic [7:0]    b_q,
   output logic          b_qv,
   output logic [AW-1:0] mem_a,
   output logic [7:0]    mem_d,
   output logic          mem_w,
   input  logic [7:0]    mem_q
);

   gnt_e          gnt;
   state_e        state, state_nxt;
   logic          starve_b;
   logic          a_wr_ok;
   logic          rd_gnt;
   logic          rd_a, rd_b;
   logic [AW-1:0] addr_hold;
   logic [7:0]    d_hold;

`ifdef ROM_WP_EN
   assign a_wr_ok = a_we & ~wp;
`else
   assign a_wr_ok = a_we;
`endif

   // Grants are gated by reset so acks and the write strobe drop immediately.
   always_comb begin
      gnt = GNT_NONE;
      if (reset) begin
         if (a_req && b_req) gnt = starve_b ? GNT_B : GNT_A;
         else if (a_req)     gnt = GNT_A;
         else if (b_req)     gnt = GNT_B;
      end
   end

   assign a_ack  = (gnt == GNT_A);
   assign b_ack  = (gnt == GNT_B);
   assign rd_gnt = (a_ack && !a_we) || (b_ack && !b_we);

   always_comb begin
      mem_a = addr_hold;
      mem_d = d_hold;
      mem_w = 1'b0;
      case (gnt)
         GNT_A: begin
            mem_a = a_addr;
            mem_d = a_d;
            mem_w = a_wr_ok;
         end
         GNT_B: begin
            mem_a = b_addr;
            mem_d = b_d;
            mem_w = b_we;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_hold <= '0;
         d_hold    <= '0;
         rd_a      <= 1'b0;
         rd_b      <= 1'b0;
         state     <= ST_IDLE;
      end else begin
         addr_hold <= mem_a;
         d_hold    <= mem_d;
         rd_a      <= a_ack && !a_we;
         rd_b      <= b_ack && !b_we;
         state     <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE:   if (rd_gnt) state_nxt = ST_RDPEND;
         ST_RDPEND: if (rd_gnt) state_nxt = ST_RDPEND;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign a_qv = rd_a && (state == ST_RDPEND);
   assign b_qv = rd_b && (state == ST_RDPEND);
   assign a_q  = mem_q;
   assign b_q  = mem_q;

   rom_arb_starve #(.MAXWAIT(MAXWAIT)) u_starve (
      .clock    (clock),
      .reset    (reset),
      .b_req    (b_req),
      .a_win    (a_ack),
      .b_win    (b_ack),
      .starve_b (starve_b)
   );

endmodule

// File: doc/rom_arb.md
Name: rom_arb

Overview:
- Two-requester arbiter and sequencer for the single-port synchronous ROM/RAM array (1-cycle read latency, write-through q).
- Port A is the CPU/memory-mapper fetch path and has priority.
- Port B is the boot/SD loader path that writes the ROM image and reads it back for verification; it is protected from starvation by a wait counter.
- Sits between the memory-page decoder and the ROM array; it is the only driver of the array's a/d/w pins.

Parameters:
- AW, 17, address width in bits (128 KB array).
- MAXWAIT, 4, maximum consecutive cycles B may lose to A before B is forced to win; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; must hold, with a_addr/a_we/a_d stable, until a_ack.
- a_addr  in  AW  port A address.
- a_we  in  1  port A write enable (1 = write).
- a_d  in  8  port A write data.
- a_ack  out  1  port A granted this cycle (combinational).
- a_q  out  8  port A read data (= mem_q).
- a_qv  out  1  a_q valid; registered, one cycle after an A read ack.
- b_req, b_addr, b_we, b_d, b_ack, b_q, b_qv: same as port A, for port B.
- mem_a  out  AW  array address.
- mem_d  out  8  array write data.
- mem_w  out  1  array write strobe.
- mem_q  in  8  array registered read data.

Behaviour:
- Grant decision is combinational each cycle from a_req, b_req and the starvation flag.
  - Neither requesting: no grant.
  - Only one requesting: that port wins.
  - Both requesting: A wins unless starve_b=1, in which case B wins.
- Granted port's addr/d/we drive mem_a/mem_d/mem_w in the same cycle; its ack is high for that single cycle.
- No grant: mem_w=0, mem_a/mem_d hold last granted values (held in registers so there is no address toggling).
- Each port's access completes in one cycle. Back-to-back grants to the same port are allowed every cycle.
- Read return: rd_a/rd_b flags are registered at the grant edge for reads only.
  - a_qv=rd_a, b_qv=rd_b, each high exactly one cycle after the read ack.
  - Data is mem_q from that read.
- Writes never raise qv.
- Starvation counter wait_b (4 bits):
  - Increments when b_req=1 and A is granted.
  - Clears when B is granted or b_req=0.
  - starve_b = (wait_b == MAXWAIT).
  - The counter saturates at MAXWAIT and does not wrap.
- State machine (2 states):
  - IDLE: no read outstanding.
  - RDPEND: a read returns this cycle.
  - IDLE->RDPEND on any read grant.
  - RDPEND->RDPEND on a read grant.
  - RDPEND->IDLE otherwise.
- Simultaneous events:
  - A read grant in RDPEND is legal; returns are pipelined.
  - a_qv and b_qv are never high together.
- Reset (asserted low, async), output values:
  - mem_w=0 forced combinationally while reset is low.
  - acks=0 while reset is low.
  - a_qv=b_qv=0, wait_b=0, mem_a=0, mem_d=0, state=IDLE.
- Reset mid-operation discards any outstanding read; no qv after release. Arbitration restarts on the first edge after release.

Optional Feature:
- ROM_WP_EN: write protect for port A.
- Defined:
  - Adds input wp (1 bit).
  - When wp=1, an A write is still acked (no CPU stall) but mem_w stays 0 and the array is unchanged.
  - B writes are never blocked.
- Undefined: no wp port; A writes always reach the array.

Decomposition:
- Package ep_rom_pkg holds:
  - ROM_AW constant (17).
  - Grant enum {GNT_NONE, GNT_A, GNT_B}.
  - State enum {ST_IDLE, ST_RDPEND}.
  - Default MAXWAIT.
- One natural sub-module: rom_arb_starve, the saturating wait counter plus starve_b compare.

Test Plan:
- Lone A read at 0x00123 from a preloaded array: a_ack same cycle, mem_w=0; a_qv=1 next cycle with a_q = array[0x00123]; b_ack stays 0.
- A and B both requesting continuously, MAXWAIT=4: grant pattern A,A,A,A,B repeating; b_ack every 5th cycle; wait_b never exceeds 4.
- B writes 0x5A to 0x1FFFF (top address), then reads it back: write cycle mem_w=1, b_qv=0; read returns 0x5A with b_qv one cycle later.
- A read issued, then reset pulsed low the next cycle: a_qv stays 0; after release all outputs are 0 and the next a_req is granted normally.
- With ROM_WP_EN and wp=1: A writes 0xFF to 0x00010 -> a_ack=1, mem_w=0; subsequent read returns the original byte. Same write from B succeeds.
- Alternating A read / B read every cycle: a_qv and b_qv alternate with correct data and are never high together.
